// File: rtl/mmio_port_bank_pkg.sv
// Shared address-map constants, region encoding and address decode helper for mmio_port_bank.
package mmio_pkg;

  localparam int unsigned DEF_PORT_COUNT     = 8;
  localparam int unsigned DEF_WORDS_PER_PORT = 2;
  localparam int unsigned STATUS_OFF         = DEF_PORT_COUNT * DEF_WORDS_PER_PORT;
  localparam int unsigned IRQ_MASK_OFF       = STATUS_OFF + 1;
  localparam int unsigned NONEMPTY_LSB       = 0;

  typedef enum logic [1:0] {
    RGN_PORT,
    RGN_STATUS,
    RGN_MASK,
    RGN_NONE
  } region_e;

  typedef struct packed {
    region_e     region;
    logic [31:0] port;
    logic [31:0] word;
  } decode_t;

  function automatic int unsigned ovf_lsb(input int unsigned n);
    return n;
  endfunction

  // Words per port is a power of two, so port/word split is a shift and a mask.
  function automatic decode_t decode_addr(input logic [31:0] off, input int unsigned n,
                                          input int unsigned w_log);
    decode_t     d;
    int unsigned nw;
    nw       = n << w_log;
    d.region = RGN_NONE;
    d.port   = '0;
    d.word   = '0;
    if (off < nw) begin
      d.region = RGN_PORT;
      d.port   = off >> w_log;
      d.word   = off & ((32'd1 << w_log) - 32'd1);
    end else if (off == nw) begin
      d.region = RGN_STATUS;
    end else if (off == nw + 1) begin
      d.region = RGN_MASK;
    end
    return d;
  endfunction

endpackage

// File: rtl/mmio_port_bank_fifo.sv
// Per-port input FIFO; each entry carries every word of one port. DEPTH is a power of two >= 2.
module mmio_port_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped port bank: output word registers, per-port input FIFOs, status register.
// Define MMIO_IRQ_EN to add the irq output and the IRQ_MASK register.
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned PORT_EXPONENT  = 3,
  parameter int unsigned WORDS_PER_PORT = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned BASE_ADDR      = 0
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    read,
  input  logic                                                    write,
  input  logic [ADDR_WIDTH-1:0]                                   addr,
  input  logic [DATA_WIDTH-1:0]                                   d_in,
  output logic [DATA_WIDTH-1:0]                                   d_out,
  input  logic [DATA_WIDTH*(2**PORT_EXPONENT)*WORDS_PER_PORT-1:0] port_d_in,
  input  logic [(2**PORT_EXPONENT)-1:0]                           port_push,
  output logic [DATA_WIDTH*(2**PORT_EXPONENT)*WORDS_PER_PORT-1:0] port_d_out,
  output logic [(2**PORT_EXPONENT)-1:0]                           port_inform_write,
  output logic [(2**PORT_EXPONENT)-1:0]                           port_inform_read
`ifdef MMIO_IRQ_EN
  ,
  output logic                                                    irq
`endif
);

  localparam int unsigned N       = 2**PORT_EXPONENT;
  localparam int unsigned W       = WORDS_PER_PORT;
  localparam int unsigned WLOG    = $clog2(W);
  localparam int unsigned NW      = N * W;
  localparam int unsigned FW      = DATA_WIDTH * W;
  localparam int unsigned PB      = (PORT_EXPONENT > 0) ? PORT_EXPONENT : 1;
  localparam int unsigned WB      = (W > 1) ? WLOG : 1;
  localparam int unsigned IW      = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned OVF_LSB = ovf_lsb(N);

  logic [ADDR_WIDTH-1:0] off;
  decode_t               dec;
  logic                  dec_unused;
  logic [PB-1:0]         sel_port;
  logic [WB-1:0]         sel_word;
  logic [IW-1:0]         sel_idx;
  logic                  sel_last;

  logic [FW-1:0]         fifo_head [N];
  logic [DATA_WIDTH-1:0] head_words [N][W];
  logic [N-1:0]          fifo_empty;
  logic [N-1:0]          fifo_full;
  logic [N-1:0]          pop;
  logic [N-1:0]          ovf_q;
  logic [N-1:0]          ovf_set;
  logic                  clr_ovf;
  logic [DATA_WIDTH-1:0] out_q [NW];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] status_word;
`ifdef MMIO_IRQ_EN
  logic [N-1:0]          mask_q;
`endif

  assign off        = addr - ADDR_WIDTH'(BASE_ADDR);
  assign dec        = decode_addr(32'(off), N, WLOG);
  assign dec_unused = ^dec;
  assign sel_port   = PB'(dec.port);
  assign sel_word   = WB'(dec.word);
  assign sel_idx    = IW'(dec.port * W + dec.word);
  assign sel_last   = (dec.word == W - 1);

  for (genvar p = 0; p < N; p++) begin : g_port
    mmio_port_fifo #(
      .WIDTH(FW),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (port_push[p]),
      .pop  (pop[p]),
      .wdata(port_d_in[p*FW +: FW]),
      .head (fifo_head[p]),
      .empty(fifo_empty[p]),
      .full (fifo_full[p])
    );
  end

  always_comb begin
    for (int unsigned p = 0; p < N; p++) begin
      for (int unsigned w = 0; w < W; w++) begin
        head_words[p][w] = fifo_head[p][w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NW; k++) begin
      port_d_out[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[NONEMPTY_LSB +: N]       = ~fifo_empty;
    status_word[OVF_LSB +: N]            = ovf_q;
  end

  always_comb begin
    rd_data = '0;
    pop     = '0;
    clr_ovf = 1'b0;
    if (read) begin
      if (dec.region == RGN_PORT) begin
        if (!fifo_empty[sel_port]) begin
          rd_data = head_words[sel_port][sel_word];
          if (sel_last) pop[sel_port] = 1'b1;
        end
      end else if (dec.region == RGN_STATUS) begin
        rd_data = status_word;
        clr_ovf = 1'b1;
      end
`ifdef MMIO_IRQ_EN
      else if (dec.region == RGN_MASK) begin
        rd_data = DATA_WIDTH'(mask_q);
      end
`endif
    end
  end

  // Overflow only when the full FIFO is not also being popped this cycle.
  assign ovf_set = port_push & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NW; k++) out_q[k] <= '0;
      ovf_q             <= '0;
      d_out             <= '0;
      port_inform_write <= '0;
      port_inform_read  <= '0;
`ifdef MMIO_IRQ_EN
      mask_q            <= '0;
      irq               <= 1'b0;
`endif
    end else begin
      port_inform_write <= '0;
      if (write && dec.region == RGN_PORT) begin
        out_q[sel_idx]              <= d_in;
        port_inform_write[sel_port] <= 1'b1;
      end
`ifdef MMIO_IRQ_EN
      if (write && dec.region == RGN_MASK) mask_q <= d_in[N-1:0];
      irq <= |(~fifo_empty & mask_q);
`endif
      if (read) d_out <= rd_data;
      port_inform_read <= pop;
      ovf_q            <= (clr_ovf ? '0 : ovf_q) | ovf_set;
    end
  end

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank; read data checked through an expectation queue.
module tb_mmio_port_bank;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int PE = 3;
  localparam int N  = 8;
  localparam int W  = 2;
  localparam int NW = N * W;

  logic              clk = 1'b0;
  logic              rst;
  logic              read;
  logic              write;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     d_in;
  logic [DW-1:0]     d_out;
  logic [DW*NW-1:0]  port_d_in;
  logic [N-1:0]      port_push;
  logic [DW*NW-1:0]  port_d_out;
  logic [N-1:0]      port_inform_write;
  logic [N-1:0]      port_inform_read;
`ifdef MMIO_IRQ_EN
  logic              irq;
`endif

  always #5 clk = ~clk;

  mmio_port_bank #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .PORT_EXPONENT (PE),
    .WORDS_PER_PORT(W),
    .FIFO_DEPTH    (4),
    .BASE_ADDR     (0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .read             (read),
    .write            (write),
    .addr             (addr),
    .d_in             (d_in),
    .d_out            (d_out),
    .port_d_in        (port_d_in),
    .port_push        (port_push),
    .port_d_out       (port_d_out),
    .port_inform_write(port_inform_write),
    .port_inform_read (port_inform_read)
`ifdef MMIO_IRQ_EN
    ,
    .irq              (irq)
`endif
  );

  int unsigned   n_asserts = 0;
  int unsigned   n_fails   = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_out [NW];

  task automatic check(input string tag, input logic [DW*NW-1:0] obs, input logic [DW*NW-1:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW*NW-1:0] flat_exp();
    logic [DW*NW-1:0] r;
    for (int k = 0; k < NW; k++) r[k*DW +: DW] = exp_out[k];
    return r;
  endfunction

  task automatic cycle(input string tag);
    logic had_read;
    had_read = read;
    @(posedge clk);
    #1;
    read      = 1'b0;
    write     = 1'b0;
    port_push = '0;
    if (had_read) begin
      if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else check(tag, d_out, sb.pop_front());
    end
  endtask

  task automatic set_port(input int p, input int w0, input int w1);
    port_d_in[(p*W+0)*DW +: DW] = DW'(w0);
    port_d_in[(p*W+1)*DW +: DW] = DW'(w1);
    port_push[p] = 1'b1;
  endtask

  task automatic push(input int p, input int w0, input int w1);
    set_port(p, w0, w1);
    cycle("push");
  endtask

  task automatic rd(input int a, input int e, input int ir, input string tag);
    addr = AW'(a);
    read = 1'b1;
    sb.push_back(DW'(e));
    cycle(tag);
    check({tag, "_inform_read"}, port_inform_read, N'(ir));
  endtask

  task automatic wr(input int a, input int v, input string tag);
    logic [N-1:0] iw;
    iw    = '0;
    addr  = AW'(a);
    d_in  = DW'(v);
    write = 1'b1;
    if (a < NW) begin
      exp_out[a] = DW'(v);
      iw[a/W]    = 1'b1;
    end
    cycle(tag);
    check({tag, "_pout"}, port_d_out, flat_exp());
    check({tag, "_inform_write"}, port_inform_write, iw);
  endtask

  initial begin
    rst       = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    addr      = '0;
    d_in      = '0;
    port_d_in = '0;
    port_push = '0;
    for (int k = 0; k < NW; k++) exp_out[k] = '0;
    cycle("reset");
    cycle("reset");
    check("reset_d_out", d_out, 0);
    check("reset_pout", port_d_out, 0);
    check("reset_inform", {port_inform_write, port_inform_read}, 0);
    rst = 1'b0;

    // Output word writes
    wr(0, 16'hA5A5, "wr_a0");
    wr(1, 16'h5A5A, "wr_a1");
    cycle("idle");
    check("inform_write_clear", port_inform_write, 0);

    // Two-word push and read-out on port 2, d_out holds between reads
    push(2, 16'h1234, 16'hBEEF);
    rd(16, 16'h0004, 0, "status_p2");
    rd(4, 16'h1234, 0, "rd_a4");
    rd(5, 16'hBEEF, 8'h04, "rd_a5");
    cycle("idle");
    check("d_out_hold", d_out, 16'hBEEF);
    check("inform_read_clear", port_inform_read, 0);
    rd(16, 16'h0000, 0, "status_p2_empty");

    // Overflow on port 1, sticky then cleared by a STATUS read
    for (int i = 1; i <= 5; i++) push(1, i, 16'h0100 + i);
    rd(16, 16'h0202, 0, "status_ovf1");
    rd(16, 16'h0002, 0, "status_ovf1_clr");
    for (int i = 1; i <= 4; i++) begin
      rd(2, i, 0, "drain1_w0");
      rd(3, 16'h0100 + i, 8'h02, "drain1_w1");
    end
    rd(3, 0, 0, "drain1_empty");

    // Full port 3: push with pop, then set-wins against STATUS clear
    for (int i = 1; i <= 4; i++) push(3, 16'h0030 + i, 16'h0040 + i);
    rd(6, 16'h0031, 0, "p3_w0_nopop");
    set_port(3, 16'h0035, 16'h0045);
    addr = AW'(7);
    read = 1'b1;
    sb.push_back(16'h0041);
    cycle("p3_push_pop");
    check("p3_push_pop_inform", port_inform_read, 8'h08);
    rd(16, 16'h0008, 0, "status_p3_noovf");
    set_port(3, 16'h0036, 16'h0046);
    addr = AW'(16);
    read = 1'b1;
    sb.push_back(16'h0008);
    cycle("status_vs_ovf");
    rd(16, 16'h0808, 0, "status_set_wins");
    rd(16, 16'h0008, 0, "status_p3_clr");
    for (int i = 2; i <= 5; i++) begin
      rd(6, 16'h0030 + i, 0, "drain3_w0");
      rd(7, 16'h0040 + i, 8'h08, "drain3_w1");
    end
    rd(7, 0, 0, "drain3_empty");

    // Out-of-range and STATUS writes, out-of-range reads
    wr(40, 16'hDEAD, "wr_oor");
    wr(16, 16'hFFFF, "wr_status");
    rd(40, 0, 0, "rd_oor");
`ifndef MMIO_IRQ_EN
    rd(17, 0, 0, "rd_mask_absent");
`endif

    // Simultaneous read and write on the same port address
    push(4, 16'h4A4A, 16'h4B4B);
    addr  = AW'(9);
    d_in  = 16'h7777;
    write = 1'b1;
    read  = 1'b1;
    exp_out[9] = 16'h7777;
    sb.push_back(16'h4B4B);
    cycle("rw_same");
    check("rw_same_pout", port_d_out, flat_exp());
    check("rw_same_inform", {port_inform_write, port_inform_read}, {8'h10, 8'h10});

`ifdef MMIO_IRQ_EN
    wr(17, 16'h0001, "wr_mask");
    rd(17, 16'h0001, 0, "rd_mask");
    push(0, 16'h0A0A, 16'h0B0B);
    check("irq_latency", irq, 0);
    cycle("idle");
    check("irq_high", irq, 1);
    rd(1, 16'h0B0B, 8'h01, "irq_pop");
    cycle("idle");
    check("irq_low", irq, 0);
`endif

    // Reset mid-drain, overriding a write and a push in the same cycle
    push(0, 16'h00C1, 16'h00D1);
    push(0, 16'h00C2, 16'h00D2);
    rd(0, 16'h00C1, 0, "pre_reset_rd");
    rst   = 1'b1;
    addr  = AW'(2);
    d_in  = 16'h3333;
    write = 1'b1;
    port_d_in[0 +: DW] = 16'h9999;
    port_push[0] = 1'b1;
    cycle("reset_mid");
    rst = 1'b0;
    for (int k = 0; k < NW; k++) exp_out[k] = '0;
    check("reset_mid_pout", port_d_out, flat_exp());
    check("reset_mid_d_out", d_out, 0);
    check("reset_mid_inform", {port_inform_write, port_inform_read}, 0);
    rd(16, 0, 0, "reset_mid_status");
    rd(1, 0, 0, "reset_mid_p0_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
